// File: rtl/pwm_dac_stage.sv
// Single-channel PWM DAC stage: a one-entry sample holding register feeds a
// free-running frame of 256 phase steps, each PRESCALE clocks long.
module pwm_dac_stage #(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       underrun_clr,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       underrun,
  output logic       busy
);
  // state | meaning
  // IDLE  | no sample seen since reset; counters parked at 0, output low
  // RUN   | free-running frames; only reset leaves this state
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [7:0]    hold;
  logic [7:0]    duty;
  logic [7:0]    phase;
  logic          hold_full;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic          boundary;
  logic          accept;
  logic          start;
  logic          load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: state_next = RUN;
    endcase
  end

  assign tick         = (state == RUN) && (ps_cnt == PS_LAST);
  assign boundary     = tick && (phase == 8'hFF);
  assign accept       = sample_valid && !hold_full;
  // accept and load never coincide: accept needs an empty hold, load a full one
  assign load         = start || (boundary && hold_full);
  assign sample_ready = !hold_full;
  assign busy         = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold        <= 8'd0;
      hold_full   <= 1'b0;
      duty        <= 8'd0;
      phase       <= 8'd0;
      ps_cnt      <= '0;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) duty <= hold;

      if (state == RUN) begin
        ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
        if (tick) phase <= phase + 8'd1;
      end

      pwm_out     <= (state == RUN) && (phase < duty);
      frame_start <= (state == RUN) && (phase == 8'd0) && (ps_cnt == '0);

      // a frame starting on an empty hold beats a simultaneous clear
      if (boundary && !hold_full) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
    end
  end

endmodule

// File: doc/pwm_dac_stage.md
PWM_DAC_STAGE -- requirements
Module: pwm_dac_stage

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clock cycles per PWM phase step; legal range 1..16.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low; asserted (0) forces reset state immediately.
REQ-004 SHALL have port sample_in  input  8  unsigned waveform sample (duty code) from the upstream wave generator.
REQ-005 SHALL have port sample_valid  input  1  upstream asserts while sample_in is valid.
REQ-006 SHALL have port sample_ready  output  1  block can accept a sample this cycle.
REQ-007 SHALL have port underrun_clr  input  1  synchronous clear of the underrun flag.
REQ-008 SHALL have port pwm_out  output  1  registered PWM bitstream to the analog filter.
REQ-009 SHALL have port frame_start  output  1  one-cycle pulse marking the first pwm_out cycle of each frame.
REQ-010 SHALL have port underrun  output  1  sticky flag: a frame started with no new sample available.
REQ-011 SHALL have port busy  output  1  high while the FSM is in RUN.

Function
REQ-012 SHALL accept a sample on a rising edge where sample_valid=1 and sample_ready=1; sample_in is stored in a one-entry holding register (hold, hold_full).
REQ-013 SHALL drive sample_ready = ~hold_full, combinationally from the register state only, with no dependence on sample_valid.
REQ-014 SHALL contain a prescale counter, 0..PRESCALE-1; tick=1 in the cycle when the counter equals PRESCALE-1, and the counter then wraps to 0.
REQ-015 SHALL contain an 8-bit phase counter that increments on tick and wraps 255->0; one frame = 256*PRESCALE clocks.
REQ-016 SHALL have FSM states IDLE and RUN.
REQ-017 In IDLE: phase=0, prescale counter=0, pwm_out=0, busy=0.
REQ-018 IDLE->RUN on the first edge where hold_full=1: duty<=hold, hold_full<=0, phase=0, frame_start pulses in the following cycle.
REQ-019 RUN is left only by reset; the block never returns to IDLE otherwise.
REQ-020 Frame boundary in RUN = the cycle with tick=1 and phase=255. If hold_full=1: duty<=hold and hold_full<=0. Otherwise: duty is kept (last sample repeats) and underrun<=1.
REQ-021 A sample accepted in the same cycle as a frame boundary SHALL go to the holding register only; there is no bypass into duty. If hold was empty, underrun is still set.
REQ-022 pwm_out SHALL be registered: pwm_out(t+1) = (phase(t) < duty(t)), unsigned 8-bit compare. Consequences: duty=0 gives constant 0; duty=255 gives 255 high phases per 256.
REQ-023 frame_start SHALL be high for exactly one cycle, the cycle in which pwm_out first reflects phase 0 of a frame; it pulses once per frame.
REQ-024 underrun SHALL be cleared on an edge with underrun_clr=1, except that a simultaneous set wins and underrun stays 1.
REQ-025 A sample offered while hold_full=1 SHALL be stalled, never dropped or overwritten; upstream holds sample_in until ready.

Reset
REQ-026 While rst=0 the block SHALL hold these values: state=IDLE, pwm_out=0, sample_ready=1, frame_start=0, underrun=0, busy=0, duty=0, hold=0, hold_full=0, phase=0, prescale counter=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; any pending held sample is discarded.
REQ-028 After rst returns to 1, the block SHALL stay in IDLE until a sample is accepted.

Verification
REQ-029 PRESCALE=1. Offer 0x80 once, then hold sample_valid=0. Required: busy=1; frame_start every 256 clocks; pwm_out high 128 of every 256 cycles; underrun=1 after the first frame.
REQ-030 Feed 0xFF, then 0x00 alternately, each offered whenever ready (upstream square wave). Required: frames alternate 255-high / 0-high; underrun stays 0.
REQ-031 PRESCALE=4, duty 0x01. Required: pwm_out high for 4 clocks per 1024-clock frame; frame_start period 1024.
REQ-032 Hold sample_valid=1 continuously. Required: sample_ready drops the cycle after acceptance and rises one cycle after each frame boundary; no sample lost, no sample duplicated.
REQ-033 Assert rst=0 at phase 100 of a 0xC0 frame. Required: pwm_out=0, busy=0, sample_ready=1 immediately without waiting for a clock edge; after release, IDLE until a new sample arrives.
REQ-034 Force underrun, then assert underrun_clr in the same cycle as the next empty-frame boundary. Required: underrun remains 1. A clear on a non-boundary cycle gives underrun=0.
